// File: rtl/clk_period_meter.sv
// clk_period_meter: period and high-time meter for a slow external clock.
// Optional build macro CPM_GLITCH_FILTER_EN rejects 1-2 clk pulses on sig_in.
module clk_period_meter #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    // Loss is declared once TIMEOUT full cycles have passed with no rise,
    // so a wave whose period is exactly TIMEOUT still measures cleanly.
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_s;
    logic                   sig_f;
    logic                   sig_d;
    logic                   rise;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       hcnt;

    // Bring the asynchronous input into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
        end
    end

    assign sig_s = sync_q[SYNC_STAGES-1];

`ifdef CPM_GLITCH_FILTER_EN
    logic [1:0] hist_q;

    // Keep the two previous synchronized samples for the stability check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= {hist_q[0], sig_s};
        end
    end

    // Follow sig_s only after three equal samples, else hold last level.
    assign sig_f = ((sig_s == hist_q[0]) && (sig_s == hist_q[1]))
                 ? sig_s : sig_d;
`else
    assign sig_f = sig_s;
`endif

    // One-cycle delayed copy of the level used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig_f;
        end
    end

    assign rise = sig_f & ~sig_d;

    // Measurement FSM: counts between rises, reports, and detects loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            hcnt       <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state   <= ARM;
                        cnt     <= ONE;
                        hcnt    <= ONE;
                        timeout <= 1'b0;
                    end
                end
                ARM, MEASURE: begin
                    if (rise) begin
                        period     <= cnt;
                        high_time  <= hcnt;
                        meas_valid <= 1'b1;
                        locked     <= 1'b1;
                        timeout    <= 1'b0;
                        cnt        <= ONE;
                        hcnt       <= ONE;
                        state      <= MEASURE;
                    end else if (cnt == TO_LIM) begin
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                        cnt     <= '0;
                        hcnt    <= '0;
                        state   <= IDLE;
                    end else begin
                        cnt  <= cnt + ONE;
                        hcnt <= hcnt + CNT_W'(sig_f);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    hcnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Testbench for clk_period_meter: directed waveforms plus random segments,
// every cycle compared against an edge-timestamp reference model.
module tb_clk_period_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1000;
    localparam int SYNC    = 2;
    localparam int HMAX    = 131072;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    int tests = 0;
    int fails = 0;

    clk_period_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: sampled input history, level per cycle, and the
    // timestamp of the last accepted rise.
    bit in_h [HMAX];
    bit lv_h [HMAX];
    int k;
    int last_rise;
    int hsum;
    int m_period;
    int m_high;
    bit m_mv;
    bit m_locked;
    bit m_tout;

    // Synchronized level during cycle j (input sampled SYNC-1 edges earlier).
    function automatic bit s_at(int j);
        int idx;
        idx = j - (SYNC - 1);
        if (idx >= 1 && idx < HMAX) return in_h[idx];
        return 1'b0;
    endfunction

    // Level the meter acts on during cycle j.
    function automatic bit level(int j);
`ifdef CPM_GLITCH_FILTER_EN
        if (s_at(j) == s_at(j - 1) && s_at(j) == s_at(j - 2)) return s_at(j);
        if (j >= 1) return lv_h[j - 1];
        return 1'b0;
`else
        return s_at(j);
`endif
    endfunction

    task automatic model_reset();
        k         = 0;
        last_rise = -1;
        hsum      = 0;
        m_period  = 0;
        m_high    = 0;
        m_mv      = 1'b0;
        m_locked  = 1'b0;
        m_tout    = 1'b0;
    endtask

    task automatic model_step();
        int j;
        bit lvl;
        bit prv;
        k = k + 1;
        in_h[k] = sig_in;
        j = k - 1;
        lvl = level(j);
        lv_h[j] = lvl;
        prv = (j >= 1) ? lv_h[j - 1] : 1'b0;
        m_mv = 1'b0;
        if (lvl && !prv) begin
            if (last_rise >= 0) begin
                m_period = j - last_rise;
                m_high   = hsum;
                m_mv     = 1'b1;
                m_locked = 1'b1;
            end
            m_tout    = 1'b0;
            last_rise = j;
            hsum      = 1;
        end else if (last_rise >= 0 && j - last_rise == TIMEOUT) begin
            m_tout    = 1'b1;
            m_locked  = 1'b0;
            last_rise = -1;
        end else if (last_rise >= 0) begin
            hsum = hsum + int'(lvl);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else if (k < HMAX - 2) model_step();
        end
    end

    // Compare process plus event monitor.
    int cyc = 0;
    int mv_cnt = 0;
    int last_mv_cyc = 0;
    int tout_rises = 0;
    int tout_rise_cyc = 0;
    bit tout_prev = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc = cyc + 1;
        if (!rst_n) begin
            tout_prev = 1'b0;
        end else begin
            tests = tests + 1;
            if (period !== CNT_W'(m_period) || high_time !== CNT_W'(m_high) ||
                meas_valid !== m_mv || locked !== m_locked ||
                timeout !== m_tout) begin
                fails = fails + 1;
                $display("FAIL model cyc=%0d got p=%0d h=%0d mv=%b lk=%b to=%b want p=%0d h=%0d mv=%b lk=%b to=%b",
                         cyc, period, high_time, meas_valid, locked, timeout,
                         m_period, m_high, m_mv, m_locked, m_tout);
            end
            if (meas_valid === 1'b1) begin
                mv_cnt = mv_cnt + 1;
                last_mv_cyc = cyc;
            end
            if (timeout === 1'b1 && !tout_prev) begin
                tout_rises = tout_rises + 1;
                tout_rise_cyc = cyc;
            end
            tout_prev = (timeout === 1'b1);
        end
    end

    task automatic check(string name, int got, int want);
        tests = tests + 1;
        if (got != want) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic wave(int hi, int lo, int n);
        for (int p = 0; p < n; p++) begin
            sig_in = 1'b1;
            repeat (hi) @(negedge clk);
            sig_in = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    // 402-clk wave with a 2-clk high glitch inside the low phase.
    task automatic gwave(int n);
        for (int p = 0; p < n; p++) begin
            sig_in = 1'b1;
            repeat (201) @(negedge clk);
            sig_in = 1'b0;
            repeat (100) @(negedge clk);
            sig_in = 1'b1;
            repeat (2) @(negedge clk);
            sig_in = 1'b0;
            repeat (99) @(negedge clk);
        end
    endtask

    int base;
    int tbase;
    int hi;
    int lo;

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("reset_period", int'(period), 0);
        check("reset_high", int'(high_time), 0);
        check("reset_flags", int'({meas_valid, locked, timeout}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: 50% duty 402-clk wave
        base = mv_cnt;
        wave(201, 201, 1);
        #1;
        check("t1_first_rise_no_strobe", mv_cnt - base, 0);
        wave(201, 201, 3);
        #1;
        check("t1_strobes", mv_cnt - base, 3);
        check("t1_period", int'(period), 402);
        check("t1_high", int'(high_time), 201);
        check("t1_locked", int'(locked), 1);
        check("t1_timeout", int'(timeout), 0);

        // 2: duty change
        wave(100, 302, 2);
        #1;
        check("t2_period", int'(period), 402);
        check("t2_high", int'(high_time), 100);

        // 3: input loss then recovery
        wave(201, 201, 2);
        tbase = tout_rises;
        sig_in = 1'b0;
        repeat (1000) @(negedge clk);
        #1;
        check("t3_timeout_raised", tout_rises - tbase, 1);
        check("t3_timeout_delay", tout_rise_cyc - last_mv_cyc, 1000);
        check("t3_timeout", int'(timeout), 1);
        check("t3_unlocked", int'(locked), 0);
        check("t3_period_hold", int'(period), 402);
        check("t3_high_hold", int'(high_time), 201);
        base = mv_cnt;
        wave(201, 201, 1);
        #1;
        check("t3_rearm_timeout_clr", int'(timeout), 0);
        check("t3_rearm_no_strobe", mv_cnt - base, 0);
        wave(201, 201, 1);
        #1;
        check("t3_relock_strobe", mv_cnt - base, 1);
        check("t3_relock", int'(locked), 1);

        // 4: asynchronous reset mid-period
        sig_in = 1'b1;
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t4_async_period", int'(period), 0);
        check("t4_async_high", int'(high_time), 0);
        check("t4_async_flags", int'({meas_valid, locked, timeout}), 0);
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = mv_cnt;
        wave(201, 201, 1);
        #1;
        check("t4_first_rise_arms", mv_cnt - base, 0);
        wave(201, 201, 1);
        #1;
        check("t4_second_rise_strobe", mv_cnt - base, 1);

        // 5: period equal to TIMEOUT
        tbase = tout_rises;
        wave(500, 500, 3);
        #1;
        check("t5_period", int'(period), 1000);
        check("t5_high", int'(high_time), 500);
        check("t5_no_timeout", tout_rises - tbase, 0);
        check("t5_timeout_lvl", int'(timeout), 0);

        // 6: 2-clk glitches in the low phase
        base = mv_cnt;
        gwave(4);
        #1;
`ifdef CPM_GLITCH_FILTER_EN
        check("t6_strobes", mv_cnt - base, 4);
        check("t6_period", int'(period), 402);
`else
        check("t6_strobes", mv_cnt - base, 8);
        check("t6_period_short", int'(period), 301);
`endif

        // random segments, model-checked every cycle
        for (int i = 0; i < 30; i++) begin
            hi = int'($urandom_range(1, 350));
            lo = ($urandom_range(0, 7) == 0) ? 1100 : int'($urandom_range(1, 350));
            wave(hi, lo, 1);
        end
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
